fetch_queue: RTL

Decoupling instruction queue between the IF stage and DC_stage. Buffers up to DEPTH fetched {pc, inst, jump} bundles in order and presents the oldest to decode through a valid/ready handshake. Flushes on backend `mispredict`. On decode's early JAL redirect (`DC_mispredict`), it squashes all wrong-path entries younger than the head.

---
 rtl/fetch_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
//------------------------------------------------------------------------------
// fetch_queue
//
// Decoupling instruction queue between the IF stage and DC_stage. Holds up to
// DEPTH fetched {pc, inst, jump} bundles in program order and presents the
// oldest one to decode through a valid/ready handshake.
//
// A backend mispredict empties the queue. An early JAL redirect from decode
// (DC_mispredict) squashes every entry younger than the head.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   IF_valid          fetch bundle valid
//   IF_pc             fetched PC
//   IF_inst           fetched instruction
//   IF_jump           fetch predicted taken
//   FQ_ready          queue can accept a bundle this cycle
//   FQ_valid          head entry valid (feeds DC_stage IF_valid)
//   DC_in_pc          head PC (0 when empty)
//   DC_in_inst        head instruction (0 when empty)
//   DC_in_jump        head predicted-taken bit (0 when empty)
//   DC_ready          decode accepts the head this cycle
//   DC_mispredict     early JAL redirect from decode, refers to the head
//   mispredict        backend flush
//   FQ_count          current occupancy, 0..DEPTH
//------------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       IF_valid,
    input  logic [31:0]                IF_pc,
    input  logic [31:0]                IF_inst,
    input  logic                       IF_jump,
    output logic                       FQ_ready,
    output logic                       FQ_valid,
    output logic [31:0]                DC_in_pc,
    output logic [31:0]                DC_in_inst,
    output logic                       DC_in_jump,
    input  logic                       DC_ready,
    input  logic                       DC_mispredict,
    input  logic                       mispredict,
    output logic [$clog2(DEPTH):0]     FQ_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [DEPTH-1:0] jump_mem;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic push;
    logic pop;
    logic redirect;

    // Ready and valid are derived only from the registered count, so a pop in
    // the same cycle never frees a slot early and there is no empty bypass.
    assign FQ_ready = (count != FULL);
    assign FQ_valid = (count != '0);
    assign push     = IF_valid && FQ_ready;
    assign pop      = FQ_valid && DC_ready;
    assign redirect = DC_mispredict && FQ_valid;
    assign FQ_count = count;

    // The head entry is read combinationally; an empty queue shows all zeros
    // so decode never sees stale contents.
    assign DC_in_pc   = FQ_valid ? pc_mem[head]   : '0;
    assign DC_in_inst = FQ_valid ? inst_mem[head] : '0;
    assign DC_in_jump = FQ_valid ? jump_mem[head] : 1'b0;

    // Pointer and occupancy state. Priority is reset, backend flush, early
    // redirect, then ordinary push/pop. On a redirect only the head survives
    // (or nothing, if decode takes it the same cycle), so tail is placed one
    // past the current head in both cases; when the head is popped that is
    // also the new head, which leaves an empty queue with head == tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (mispredict) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            tail <= head + PTR_ONE;
            if (pop) begin
                head  <= head + PTR_ONE;
                count <= '0;
            end else begin
                count <= CW'(1);
            end
        end else begin
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage. Writes follow the same priority as the pointers: a push
    // is dropped by any flush. When the redirecting JAL stays at the head its
    // jump bit is forced high so decode does not raise the redirect again on
    // the same instruction in later cycles.
    always_ff @(posedge clk) begin
        if (!rst && !mispredict) begin
            if (redirect) begin
                if (!pop) begin
                    jump_mem[head] <= 1'b1;
                end
            end else if (push) begin
                pc_mem[tail]   <= IF_pc;
                inst_mem[tail] <= IF_inst;
                jump_mem[tail] <= IF_jump;
            end
        end
    end

endmodule
